// File: rtl/divider.sv
// Iterative restoring divider: n-bit dividend / n-bit divisor, signed or
// unsigned, one quotient bit per clock with a start/busy/done handshake.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

module divider #(
  parameter int n = `DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         sign,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] quot,
  output logic [n-1:0] rem,
  output logic         div_zero
);

  localparam int CW = $clog2(n + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic           r_as;
  logic           r_bs;
  logic           r_bzero;
  logic [n-1:0]   r_a_orig;
  logic [n-1:0]   r_dvd;      // dividend magnitude shifts out MSB-first, quotient bits shift in
  logic [n-1:0]   r_dvs;
  logic [n-1:0]   r_prem;     // partial remainder; always < |b| so n bits hold it between steps
  logic [CW-1:0]  r_cnt;
  logic           r_done;
  logic [n-1:0]   r_quot;
  logic [n-1:0]   r_rem;
  logic           r_div_zero;

  logic           w_as;
  logic           w_bs;
  logic [n-1:0]   w_amag;
  logic [n-1:0]   w_bmag;
  logic [n:0]     w_trial;
  logic           w_ge;
  logic [n-1:0]   w_diff;
  logic [n-1:0]   w_prem_nxt;
  logic [n-1:0]   w_quot_fix;
  logic [n-1:0]   w_rem_fix;

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign quot     = r_quot;
  assign rem      = r_rem;
  assign div_zero = r_div_zero;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state: accept in IDLE, n restoring steps in CALC, one fixup cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_CALC;
      S_CALC:  if (r_cnt == CW'(1)) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand magnitudes, one restoring step, and final sign fixup
  always_comb begin
    w_as       = sign & a[n-1];
    w_bs       = sign & b[n-1];
    w_amag     = w_as ? -a : a;
    w_bmag     = w_bs ? -b : b;
    // n+1-bit trial remainder; when it is >= |b| the difference fits in n bits
    w_trial    = {r_prem, r_dvd[n-1]};
    w_ge       = (w_trial >= {1'b0, r_dvs});
    w_diff     = w_trial[n-1:0] - r_dvs;
    w_prem_nxt = w_ge ? w_diff : w_trial[n-1:0];
    w_quot_fix = r_bzero ? '1 : ((r_as ^ r_bs) ? -r_dvd : r_dvd);
    w_rem_fix  = r_bzero ? r_a_orig : (r_as ? -r_prem : r_prem);
  end

  // Datapath: capture on accept, iterate in CALC, register results in FIX
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_as       <= 1'b0;
      r_bs       <= 1'b0;
      r_bzero    <= 1'b0;
      r_a_orig   <= '0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_prem     <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_as     <= w_as;
            r_bs     <= w_bs;
            r_bzero  <= (b == '0);
            r_a_orig <= a;
            r_dvd    <= w_amag;
            r_dvs    <= w_bmag;
            r_prem   <= '0;
            r_cnt    <= CW'(n);
          end
        end
        S_CALC: begin
          r_prem <= w_prem_nxt;
          r_dvd  <= {r_dvd[n-2:0], w_ge};
          r_cnt  <= r_cnt - CW'(1);
        end
        S_FIX: begin
          r_quot     <= w_quot_fix;
          r_rem      <= w_rem_fix;
          r_div_zero <= r_bzero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the divider at n=8.
`timescale 1ns/1ps

module tb_divider;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       sign;
  logic       busy;
  logic       done;
  logic [7:0] quot;
  logic [7:0] rem;
  logic       div_zero;

  int tests;
  int failed;

  divider #(.n(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .sign(sign),
    .busy(busy), .done(done), .quot(quot), .rem(rem), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands with start=1 and consume the accepting edge; returns #1 after it.
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts);
    a = ta; b = tb; sign = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen (#1 after each edge); -1 on timeout.
  task automatic wait_done(input int already, output int edges);
    edges = already;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      edges++;
      if (done) return;
    end
    edges = -1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #2;
    tests++; if (busy !== 1'b0)     begin failed++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (done !== 1'b0)     begin failed++; $display("FAIL reset_done got %b exp 0", done); end
    tests++; if (quot !== 8'h00)    begin failed++; $display("FAIL reset_quot got %h exp 00", quot); end
    tests++; if (rem !== 8'h00)     begin failed++; $display("FAIL reset_rem got %h exp 00", rem); end
    tests++; if (div_zero !== 1'b0) begin failed++; $display("FAIL reset_dz got %b exp 0", div_zero); end
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    int e;
    start_op(8'd100, 8'd7, 1'b0);
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL uns_busy_after_accept got %b exp 1", busy); end
    wait_done(0, e);
    tests++; if (e != 9)           begin failed++; $display("FAIL uns_latency got %0d exp 9", e); end
    tests++; if (quot !== 8'd14)   begin failed++; $display("FAIL uns_quot got %0d exp 14", quot); end
    tests++; if (rem !== 8'd2)     begin failed++; $display("FAIL uns_rem got %0d exp 2", rem); end
    tests++; if (div_zero !== 1'b0) begin failed++; $display("FAIL uns_dz got %b exp 0", div_zero); end
    tests++; if (busy !== 1'b0)    begin failed++; $display("FAIL uns_busy_in_done got %b exp 0", busy); end
    @(posedge clk); #1;
    tests++; if (done !== 1'b0)    begin failed++; $display("FAIL uns_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_signed();
    int e;
    start_op(8'hF9, 8'h02, 1'b1);
    wait_done(0, e);
    tests++; if (e != 9)         begin failed++; $display("FAIL sgn1_latency got %0d exp 9", e); end
    tests++; if (quot !== 8'hFD) begin failed++; $display("FAIL sgn1_quot got %h exp fd", quot); end
    tests++; if (rem !== 8'hFF)  begin failed++; $display("FAIL sgn1_rem got %h exp ff", rem); end
    @(posedge clk); #1;
    start_op(8'h07, 8'hFE, 1'b1);
    wait_done(0, e);
    tests++; if (e != 9)         begin failed++; $display("FAIL sgn2_latency got %0d exp 9", e); end
    tests++; if (quot !== 8'hFD) begin failed++; $display("FAIL sgn2_quot got %h exp fd", quot); end
    tests++; if (rem !== 8'h01)  begin failed++; $display("FAIL sgn2_rem got %h exp 01", rem); end
  endtask

  task automatic test_div_zero();
    int e;
    start_op(8'h85, 8'h00, 1'b1);
    wait_done(0, e);
    tests++; if (e != 9)            begin failed++; $display("FAIL dz_latency got %0d exp 9", e); end
    tests++; if (quot !== 8'hFF)    begin failed++; $display("FAIL dz_quot got %h exp ff", quot); end
    tests++; if (rem !== 8'h85)     begin failed++; $display("FAIL dz_rem got %h exp 85", rem); end
    tests++; if (div_zero !== 1'b1) begin failed++; $display("FAIL dz_flag got %b exp 1", div_zero); end
    @(posedge clk); #1;
    tests++; if (div_zero !== 1'b1) begin failed++; $display("FAIL dz_hold got %b exp 1", div_zero); end
    start_op(8'd10, 8'd3, 1'b0);
    wait_done(0, e);
    tests++; if (div_zero !== 1'b0) begin failed++; $display("FAIL dz_clear got %b exp 0", div_zero); end
    tests++; if (quot !== 8'd3)     begin failed++; $display("FAIL dz_next_quot got %0d exp 3", quot); end
    tests++; if (rem !== 8'd1)      begin failed++; $display("FAIL dz_next_rem got %0d exp 1", rem); end
  endtask

  task automatic test_overflow();
    int e;
    start_op(8'h80, 8'hFF, 1'b1);
    wait_done(0, e);
    tests++; if (quot !== 8'h80)    begin failed++; $display("FAIL ovf_quot got %h exp 80", quot); end
    tests++; if (rem !== 8'h00)     begin failed++; $display("FAIL ovf_rem got %h exp 00", rem); end
    tests++; if (div_zero !== 1'b0) begin failed++; $display("FAIL ovf_dz got %b exp 0", div_zero); end
    @(posedge clk); #1;
    start_op(8'h80, 8'hFF, 1'b0);
    wait_done(0, e);
    tests++; if (quot !== 8'h00) begin failed++; $display("FAIL umax_quot got %h exp 00", quot); end
    tests++; if (rem !== 8'h80)  begin failed++; $display("FAIL umax_rem got %h exp 80", rem); end
  endtask

  task automatic test_ignored_start();
    int e;
    start_op(8'd200, 8'd10, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    // new request and operand changes while busy must both be ignored
    a = 8'd50; b = 8'd5; sign = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 8'hF0; b = 8'h03;
    wait_done(4, e);
    tests++; if (e != 9)          begin failed++; $display("FAIL ign_latency got %0d exp 9", e); end
    tests++; if (quot !== 8'd20)  begin failed++; $display("FAIL ign_quot got %0d exp 20", quot); end
    tests++; if (rem !== 8'd0)    begin failed++; $display("FAIL ign_rem got %0d exp 0", rem); end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0)   begin failed++; $display("FAIL ign_no_queue got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    int e;
    start_op(8'd100, 8'd7, 1'b0);
    wait_done(0, e);
    tests++; if (e != 9) begin failed++; $display("FAIL b2b_first_latency got %0d exp 9", e); end
    start_op(8'd10, 8'd3, 1'b0);
    tests++; if (done !== 1'b0) begin failed++; $display("FAIL b2b_done_single got %b exp 0", done); end
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL b2b_accepted got %b exp 1", busy); end
    wait_done(0, e);
    tests++; if (e != 9)        begin failed++; $display("FAIL b2b_latency got %0d exp 9", e); end
    tests++; if (quot !== 8'd3) begin failed++; $display("FAIL b2b_quot got %0d exp 3", quot); end
    tests++; if (rem !== 8'd1)  begin failed++; $display("FAIL b2b_rem got %0d exp 1", rem); end
  endtask

  task automatic test_reset_mid();
    int e;
    start_op(8'd255, 8'd1, 1'b0);
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0)     begin failed++; $display("FAIL rmid_busy got %b exp 0", busy); end
    tests++; if (done !== 1'b0)     begin failed++; $display("FAIL rmid_done got %b exp 0", done); end
    tests++; if (quot !== 8'h00)    begin failed++; $display("FAIL rmid_quot got %h exp 00", quot); end
    tests++; if (rem !== 8'h00)     begin failed++; $display("FAIL rmid_rem got %h exp 00", rem); end
    tests++; if (div_zero !== 1'b0) begin failed++; $display("FAIL rmid_dz got %b exp 0", div_zero); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    start_op(8'd200, 8'd16, 1'b0);
    wait_done(0, e);
    tests++; if (e != 9)         begin failed++; $display("FAIL rmid_latency got %0d exp 9", e); end
    tests++; if (quot !== 8'd12) begin failed++; $display("FAIL rmid_quot2 got %0d exp 12", quot); end
    tests++; if (rem !== 8'd8)   begin failed++; $display("FAIL rmid_rem2 got %0d exp 8", rem); end
  endtask

  initial begin
    tests = 0; failed = 0;
    start = 1'b0; a = '0; b = '0; sign = 1'b0; reset_n = 1'b1;
    test_reset();
    test_unsigned();
    test_signed();
    @(posedge clk); #1;
    test_div_zero();
    @(posedge clk); #1;
    test_overflow();
    @(posedge clk); #1;
    test_ignored_start();
    test_back_to_back();
    @(posedge clk); #1;
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
